// File: rtl/hack_pkg.sv
// Shared Hack datapath definitions: machine word width and word type.
package hack_pkg;

  localparam int unsigned HACK_WORD_W = 16;

  typedef logic [HACK_WORD_W-1:0] hack_word_t;

endpackage

// File: rtl/hack_and16_bitwise.sv
// Purely combinational WIDTH-wide bitwise AND.
module hack_and16_bitwise
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/hack_and16_core.sv
// Registered bitwise AND stage with valid/ready handshakes on both sides.
// Optional zr/ng result flags are enabled by defining HACK_AND16_FLAGS_EN.
module hack_and16_core
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HACK_AND16_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_d, valid_q;
  logic             accept;

  hack_and16_bitwise #(
    .WIDTH(WIDTH)
  ) u_bitwise (
    .a(a),
    .b(b),
    .y(and_res)
  );

  // Empty, or draining this cycle, so a new result can take the slot with no bubble.
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (accept) begin
      out_d   = and_res;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

`ifdef HACK_AND16_FLAGS_EN
  logic zr_q, ng_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else if (accept) begin
      zr_q <= ~|and_res;
      ng_q <= and_res[WIDTH-1];
    end
  end

  assign zr = zr_q;
  assign ng = ng_q;
`endif

endmodule

// File: tb/tb_hack_and16_core.sv
// Self-checking bench for hack_and16_core: directed vectors plus randomized handshake traffic.
module tb_hack_and16_core;
  import hack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  hack_word_t a, b, out;
  logic       in_valid, in_ready, out_valid, out_ready;
`ifdef HACK_AND16_FLAGS_EN
  logic       zr, ng;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one-slot buffer holding the last accepted result.
  hack_word_t m_out;
  logic       m_valid;
  logic       m_zr, m_ng;

  hack_and16_core #(
    .WIDTH(HACK_WORD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef HACK_AND16_FLAGS_EN
    ,
    .zr       (zr),
    .ng       (ng)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out   = '0;
    m_valid = 1'b0;
    m_zr    = 1'b0;
    m_ng    = 1'b0;
  endtask

  // One clock of traffic: drive at negedge, check in_ready, then check registered outputs.
  task automatic step(input logic v, input hack_word_t ta, input hack_word_t tb_,
                      input logic rdy);
    logic acc;
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb_;
    out_ready = rdy;
    #1;
    check_eq("in_ready", in_ready, {31'b0, !m_valid || rdy});
    acc = v && (!m_valid || rdy);
    @(posedge clk);
    #1;
    if (acc) begin
      m_out   = ta & tb_;
      m_valid = 1'b1;
      m_zr    = (m_out == 0);
      m_ng    = m_out[HACK_WORD_W-1];
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    check_eq("out_valid", out_valid, {31'b0, m_valid});
    check_eq("out", out, {16'b0, m_out});
`ifdef HACK_AND16_FLAGS_EN
    check_eq("zr", zr, {31'b0, m_zr});
    check_eq("ng", ng, {31'b0, m_ng});
`endif
  endtask

  hack_word_t va[5] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
  hack_word_t vb[5] = '{16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};
  hack_word_t vy[5] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0CC0, 16'h1034};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    model_reset();
    #1;
    check_eq("reset_out", out, 0);
    check_eq("reset_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vectors back-to-back: no bubbles, in_ready held high.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, va[i], vb[i], 1'b1);
      check_eq("vec_out", out, {16'b0, vy[i]});
      check_eq("vec_valid", out_valid, 1);
    end

    // Backpressure: result holds and in_ready stays low while stalled.
    step(1'b1, 16'h3CC3, 16'h0FF0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
      check_eq("stall_out", out, 16'h0CC0);
      check_eq("stall_in_ready", in_ready, 0);
    end
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check_eq("unstall_out", out, 16'hFFFF);

    // Drain: valid for exactly one cycle, data held afterwards.
    step(1'b1, 16'h1234, 16'h9876, 1'b1);
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    check_eq("drain_valid", out_valid, 0);
    check_eq("drain_out", out, 16'h1034);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    check_eq("drain_hold", out, 16'h1034);

`ifdef HACK_AND16_FLAGS_EN
    step(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    check_eq("flag_zr_1", zr, 1);
    check_eq("flag_ng_0", ng, 0);
    step(1'b1, 16'hFFFF, 16'h8001, 1'b1);
    check_eq("flag_zr_0", zr, 0);
    check_eq("flag_ng_1", ng, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), hack_word_t'($urandom), hack_word_t'($urandom),
           1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset mid-stream with a pending result.
    step(1'b1, 16'hF0F0, 16'hFF00, 1'b0);
    check_eq("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_reset_out", out, 0);
    check_eq("async_reset_valid", out_valid, 0);
`ifdef HACK_AND16_FLAGS_EN
    check_eq("async_reset_zr", zr, 0);
    check_eq("async_reset_ng", ng, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h00FF, 16'h0F0F, 1'b1);
    check_eq("post_reset_out", out, 16'h000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_and16_core.md
Name: hack_and16_core

Overview:
- Registered 16-bit bitwise AND unit for the Hack ALU datapath: out = a & b, one bit per lane, no carries.
- Combinational AND feeding a single pipeline register with valid/ready handshakes on input and output.
- Sits between operand selection and the ALU result mux.
- Replaces the purely combinational gate where timing needs a register stage.

Parameters:
- WIDTH, 16: operand/result width in bits. Only 16 is verified; other values must elaborate cleanly.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_valid  input  1  a/b valid this cycle
- in_ready  output  1  stage can accept a/b
- out  output  WIDTH  registered a & b
- out_valid  output  1  out holds an unconsumed result
- out_ready  input  1  downstream accepts out

Behaviour:
- One clock, one asynchronous active-low reset. Reset asserts immediately, independent of clk; release is sampled on rising clk.
- Reset values: out = 0, out_valid = 0.
- in_ready = ~out_valid | out_ready (combinational). The stage accepts new data when empty or when its current result drains in the same cycle.
- Input accept: in_valid & in_ready on a rising clk edge. Then out <= a & b, out_valid <= 1.
- Output drain without new input: when out_valid & out_ready & ~(in_valid & in_ready), out_valid <= 0. out keeps its last value.
- Simultaneous drain and accept: the new result replaces the old with no bubble, and out_valid stays 1. Throughput is one result per cycle.
- Stall: while out_valid = 1 and out_ready = 0:
  - out and out_valid hold.
  - in_ready = 0.
  - a/b are ignored.
- Latency: exactly 1 cycle from accept to out_valid.
- Arithmetic: pure bitwise AND. out[i] = a[i] & b[i] for every i. No sign, carry or overflow.
- Reset mid-operation: any pending result is discarded and out_valid drops asynchronously.
- Data is don't-care when in_valid = 0. out changes only on accept or reset.

Optional Feature:
- Macro: HACK_AND16_FLAGS_EN.
- Defined: two extra outputs, registered alongside out and updated only on accept, both reset to 0.
  - zr  output 1: set when a & b == 0.
  - ng  output 1: equals (a & b)[WIDTH-1].
- Undefined: zr and ng ports do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package hack_pkg holds:
  - HACK_WORD_W = 16.
  - typedef hack_word_t as logic [HACK_WORD_W-1:0].
- Sub-module hack_and16_bitwise: purely combinational WIDTH-wide AND.
- hack_and16_core: instantiates hack_and16_bitwise and adds the register, handshake and flags.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with out_valid = 1 -> out = 0x0000 and out_valid = 0 immediately, without waiting for a clock edge.
- Basic vectors, out_ready = 1, accepted one per cycle -> out sequence, each one cycle after accept:
  - 0x0000 & 0xFFFF -> 0x0000
  - 0xFFFF & 0xFFFF -> 0xFFFF
  - 0xAAAA & 0x5555 -> 0x0000
  - 0x3CC3 & 0x0FF0 -> 0x0CC0
  - 0x1234 & 0x9876 -> 0x1034
- Back-to-back: continuous in_valid = 1 and out_ready = 1 for 5 vectors -> 5 consecutive out_valid cycles with no bubbles and in_ready constantly 1.
- Backpressure: accept 0x3CC3 & 0x0FF0, hold out_ready = 0 for 3 cycles while presenting 0xFFFF & 0xFFFF ->
  - out stays 0x0CC0 and in_ready = 0 throughout.
  - When out_ready rises, the next result is 0xFFFF.
- Drain: single accept, then in_valid = 0 and out_ready = 1 -> out_valid is high for exactly 1 cycle, then 0, with out held at the last value.
- Flags (HACK_AND16_FLAGS_EN):
  - 0xAAAA & 0x5555 -> zr = 1, ng = 0.
  - 0xFFFF & 0x8001 -> zr = 0, ng = 1.
